// File: rtl/uart_tx_path.sv
// UART transmit path: small TX FIFO, free-running 16x baud tick and an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when par_odd is high).
module uart_tx_path #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8,
    parameter int FIFO_W   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_uart,
    input  logic [7:0] w_data,
`ifdef UART_TX_PARITY_EN
    input  logic       par_odd,
`endif
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);
    localparam int DEPTH = 1 << FIFO_W;
    localparam int NB_W  = (DBIT > 1) ? $clog2(DBIT) : 1;
    // Sample counter widens when the stop period needs more than 16 ticks.
    localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY     = 3'd4;
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    logic [DVSR_BIT-1:0] baud_cnt;
    logic                tick;

    assign tick = (baud_cnt == DVSR_BIT'(DVSR - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            baud_cnt <= '0;
        else if (tick)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr, rd_ptr;
    logic [FIFO_W:0]   count;
    logic              full, empty, push, pop;

    assign full  = (count == (FIFO_W + 1)'(DEPTH));
    assign empty = (count == '0);
    // A write while full is dropped even if the FSM frees a slot this cycle.
    assign push  = wr_uart && !full;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= w_data[DBIT-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    logic [2:0]      state, state_n;
    logic [S_W-1:0]  s, s_n;
    logic [NB_W-1:0] n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic            tx_reg, tx_n;
    logic            done;
`ifdef UART_TX_PARITY_EN
    logic            par, par_n;
`endif

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        pop     = 1'b0;
        done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    b_n     = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    par_n   = ^mem[rd_ptr];
`endif
                    s_n     = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s == S_W'(15)) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = ST_DATA;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s == S_W'(15)) begin
                        s_n = '0;
                        b_n = b >> 1;
                        if (n == NB_W'(DBIT - 1))
                            state_n = ST_AFTER_DATA;
                        else
                            n_n = n + 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s == S_W'(15)) begin
                        s_n     = '0;
                        state_n = ST_STOP;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (s == S_W'(SB_TICK - 1)) begin
                        state_n = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Line level follows the state being entered, so tx lines up with state.
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = b_n[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_n = par_n ^ par_odd;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            s      <= '0;
            n      <= '0;
            tx_reg <= 1'b1;
        end else begin
            state  <= state_n;
            s      <= s_n;
            n      <= n_n;
            tx_reg <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        b <= b_n;
`ifdef UART_TX_PARITY_EN
        par <= par_n;
`endif
    end

    assign tx           = tx_reg;
    assign tx_full      = full;
    assign tx_busy      = (state != ST_IDLE) || !empty;
    assign tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx_path.sv
// Bench for uart_tx_path: frame-level tick-counting reference model, line decoder and directed
// plus random byte streams. Parity checks are compiled in when UART_TX_PARITY_EN is defined.
module tb_uart_tx_path;
    localparam int DBIT     = 8;
    localparam int DVSR     = 2;
    localparam int DVSR_BIT = 8;
    localparam int FIFO_W   = 2;
    localparam int DEPTH    = 4;
    localparam int SB_TICK  = 16;
    localparam int SB_LONG  = 32;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int TOTAL   = 16 * (1 + DBIT + PAR_BITS) + SB_TICK;
    localparam int BIT_CLK = 16 * DVSR;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_uart = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       wr32 = 1'b0;
    logic [7:0] w_data32 = 8'h00;
`ifdef UART_TX_PARITY_EN
    logic       par_odd = 1'b0;
    logic       last_par = 1'b0;
`endif
    logic tx_full, tx_busy, tx_done_tick, tx;
    logic tx_full32, tx_busy32, done32, tx32;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_path #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .DVSR_BIT(DVSR_BIT),
                   .FIFO_W(FIFO_W)) u_dut (
        .clk(clk), .reset(reset), .wr_uart(wr_uart), .w_data(w_data),
`ifdef UART_TX_PARITY_EN
        .par_odd(par_odd),
`endif
        .tx_full(tx_full), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
    );

    uart_tx_path #(.DBIT(DBIT), .SB_TICK(SB_LONG), .DVSR(DVSR), .DVSR_BIT(DVSR_BIT),
                   .FIFO_W(FIFO_W)) u_dut32 (
        .clk(clk), .reset(reset), .wr_uart(wr32), .w_data(w_data32),
`ifdef UART_TX_PARITY_EN
        .par_odd(par_odd),
`endif
        .tx_full(tx_full32), .tx_busy(tx_busy32), .tx_done_tick(done32), .tx(tx32)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a frame is TOTAL baud ticks long, counted from the clock after the pop.
    logic [7:0] held[$];
    logic [7:0] acc_q[$];
    logic [7:0] cur = 8'h00;
    int m_rem = 0;
    int m_cnt = 0;

    initial begin : ref_model
        bit tick_m, push_m;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                held.delete();
                m_rem = 0;
                m_cnt = 0;
            end else begin
                tick_m = (m_cnt == DVSR - 1);
                push_m = (wr_uart === 1'b1) && (held.size() < DEPTH);
                if (m_rem == 0) begin
                    if (held.size() != 0) begin
                        cur   = held.pop_front();
                        m_rem = TOTAL;
                    end
                end else if (tick_m) begin
                    m_rem--;
                end
                if (push_m) begin
                    held.push_back(w_data);
                    acc_q.push_back(w_data);
                end
                m_cnt = tick_m ? 0 : m_cnt + 1;
            end
        end
    end

    function automatic logic line_ref(input logic [7:0] c, input int rem);
        int bitno;
        if (rem == 0) return 1'b1;
        bitno = (TOTAL - rem) / 16;
        if (bitno == 0) return 1'b0;
        if (bitno <= DBIT) return c[bitno-1];
`ifdef UART_TX_PARITY_EN
        if (bitno == DBIT + 1) return (^c) ^ par_odd;
`endif
        return 1'b1;
    endfunction

    bit chk_en = 1'b0;
    initial begin : cycle_checker
        forever begin
            @(negedge clk);
            if (chk_en && reset === 1'b0) begin
                check_eq("tx", 32'(tx), 32'(line_ref(cur, m_rem)));
                check_eq("tx_full", 32'(tx_full), 32'(held.size() == DEPTH));
                check_eq("tx_busy", 32'(tx_busy), 32'((m_rem != 0) || (held.size() != 0)));
                check_eq("tx_done_tick", 32'(tx_done_tick), 32'((m_rem == 1) && (m_cnt == DVSR - 1)));
            end
        end
    end

    int done_cnt = 0;
    int done32_cnt = 0;
    int rst_cnt = 0;
    always @(negedge clk) if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
    always @(negedge clk) if (done32 === 1'b1) done32_cnt <= done32_cnt + 1;
    always @(posedge reset) rst_cnt <= rst_cnt + 1;

    // Line decoder: samples each bit near its middle, abandons a frame cut by reset.
    logic [7:0] rx_q[$];
    initial begin : decoder
        logic [7:0] v;
        int snap;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || tx !== 1'b0) continue;
            snap = rst_cnt;
            repeat (BIT_CLK / 2 - 1) @(negedge clk);
            if (snap != rst_cnt) continue;
            check_eq("start_bit", 32'(tx), 32'd0);
            for (int k = 0; k < DBIT; k++) begin
                repeat (BIT_CLK) @(negedge clk);
                v[k] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (BIT_CLK) @(negedge clk);
            last_par = tx;
`endif
            repeat (BIT_CLK) @(negedge clk);
            if (snap != rst_cnt) continue;
            check_eq("stop_bit", 32'(tx), 32'd1);
`ifdef UART_TX_PARITY_EN
            check_eq("parity_bit", 32'(last_par), 32'((^v) ^ par_odd));
`endif
            rx_q.push_back(v);
        end
    end

    task automatic write_byte(input logic [7:0] d);
        w_data  = d;
        wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) seen = 1'b1;
        end
        check_eq({tag, "_idle"}, 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_rx(input string tag, input int n, input logic [63:0] bytes);
        check_eq({tag, "_nbytes"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) check_eq({tag, "_byte"}, 32'(rx_q[i]), 32'(bytes[8*i +: 8]));
        end
        rx_q.delete();
        acc_q.delete();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int d0, run, low_cnt;
        bit ok;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_full", 32'(tx_full), 32'd0);
        check_eq("rst_done", 32'(tx_done_tick), 32'd0);
        check_eq("rst_tx32", 32'(tx32), 32'd1);
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (10) @(negedge clk);

        // Single byte
        d0 = done_cnt;
        write_byte(8'h55);
        wait_idle("single", 1000);
        check_eq("single_done", 32'(done_cnt - d0), 32'd1);
        check_rx("single", 1, 64'h55);

        // Back-to-back
        d0 = done_cnt;
        write_byte(8'hA3);
        write_byte(8'h0F);
        write_byte(8'hFF);
        wait_idle("b2b", 1500);
        check_eq("b2b_done", 32'(done_cnt - d0), 32'd3);
        check_rx("b2b", 3, 64'hFF_0F_A3);

        // Full / drop: the sixth write lands while four bytes are held
        d0 = done_cnt;
        for (int i = 1; i <= 6; i++) begin
            write_byte(8'(i));
            if (i == 5) check_eq("full_after5", 32'(tx_full), 32'd1);
        end
        wait_idle("full", 2500);
        check_eq("full_done", 32'(done_cnt - d0), 32'd5);
        check_rx("full", 5, 64'h05_04_03_02_01);

        // Long stop period on the SB_TICK=32 instance
        w_data32 = 8'h00;
        wr32 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wr32 = 1'b0;
        check_eq("full32", 32'(tx_full32), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (tx32 === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
        check_eq("stop32_start", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (tx32 === 1'b1) ok = 1'b1;
        end
        check_eq("stop32_rise", 32'(ok), 32'd1);
        run = 0;
        ok  = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (tx32 === 1'b1) begin
                run++;
                @(negedge clk);
            end else begin
                ok = 1'b1;
            end
        end
        check_eq("stop32_next_start", 32'(ok), 32'd1);
        check_eq("stop32_len", 32'((run >= SB_LONG * DVSR) && (run <= SB_LONG * DVSR + 1)), 32'd1);
        d0 = done32_cnt;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (tx_busy32 === 1'b0) ok = 1'b1;
        end
        check_eq("stop32_idle", 32'(ok), 32'd1);
        check_eq("stop32_done", 32'(done32_cnt - d0), 32'd1);

`ifdef UART_TX_PARITY_EN
        par_odd = 1'b0;
        write_byte(8'h07);
        wait_idle("par_even", 800);
        check_eq("par_even_bit", 32'(last_par), 32'd1);
        check_rx("par_even", 1, 64'h07);
        par_odd = 1'b1;
        write_byte(8'h07);
        wait_idle("par_odd", 800);
        check_eq("par_odd_bit", 32'(last_par), 32'd0);
        check_rx("par_odd", 1, 64'h07);
        par_odd = 1'b0;
`endif

        // Random stream: bursts that overrun the FIFO mixed with idle gaps
        for (int i = 0; i < 60; i++) begin
            int gap;
            write_byte(8'($urandom_range(0, 255)));
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 700) : $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        wait_idle("rand", 30000);
        check_eq("rand_nbytes", 32'(rx_q.size()), 32'(acc_q.size()));
        for (int i = 0; i < acc_q.size(); i++) begin
            if (i < rx_q.size()) check_eq("rand_byte", 32'(rx_q[i]), 32'(acc_q[i]));
        end
        rx_q.delete();
        acc_q.delete();

        // Reset mid-frame with a full FIFO
        for (int i = 0; i < 5; i++) write_byte(8'h00);
        check_eq("pre_rst_full", 32'(tx_full), 32'd1);
        repeat (100) @(negedge clk);
        check_eq("pre_rst_tx", 32'(tx), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_tx", 32'(tx), 32'd1);
        check_eq("midrst_busy", 32'(tx_busy), 32'd0);
        check_eq("midrst_full", 32'(tx_full), 32'd0);
        check_eq("midrst_done", 32'(tx_done_tick), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
        end
        check_eq("idle_tx_low", 32'(low_cnt), 32'd0);
        check_eq("idle_nbytes", 32'(rx_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
